led_trail_fader: RTL and testbench

LED_TRAIL_FADER -- requirements
Module: led_trail_fader

---
 rtl/led_trail_fader.sv | 85 ++++++++
 tb/tb_led_trail_fader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_trail_fader.sv
// Eight-channel LED trail fader: each channel jumps to full brightness when its
// led_in bit is set and fades one level per DECAY_DIV enabled clocks, PWM-dimmed.
module led_trail_fader #(
  parameter int unsigned LVL_W     = 4,
  parameter int unsigned DECAY_DIV = 1024
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic [7:0] led_in,
  output logic [7:0] led_out,
  output logic       pwm_wrap,
  output logic       busy
);

  localparam int unsigned NCH   = 8;
  localparam int unsigned DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX  = {LVL_W{1'b1}};
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_DIV - 1);

  logic [LVL_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [LVL_W-1:0] level_q [NCH];
  logic [LVL_W-1:0] level_d [NCH];
  logic [NCH-1:0]   led_out_q, led_out_d;
  logic             pwm_wrap_q, pwm_wrap_d;
  logic             decay_tick;

  // PWM counter and decay prescaler, both frozen while en is low
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    pwm_wrap_d = 1'b0;
    decay_tick = en && (dec_cnt_q == DEC_LAST);
    if (en) begin
      pwm_cnt_d  = pwm_cnt_q + LVL_W'(1);
      pwm_wrap_d = (pwm_cnt_q == LVL_MAX);
      dec_cnt_d  = decay_tick ? '0 : dec_cnt_q + DEC_W'(1);
    end
  end

  // Per-channel level: load wins over decay, decay saturates at zero
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      level_d[i] = level_q[i];
      if (led_in[i]) begin
        level_d[i] = LVL_MAX;
      end else if (decay_tick && (level_q[i] != '0)) begin
        level_d[i] = level_q[i] - LVL_W'(1);
      end
      led_out_d[i] = (level_q[i] == LVL_MAX) || (level_q[i] > pwm_cnt_q);
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      busy = busy | (level_q[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pwm_cnt_q  <= '0;
      dec_cnt_q  <= '0;
      led_out_q  <= '0;
      pwm_wrap_q <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      led_out_q  <= led_out_d;
      pwm_wrap_q <= pwm_wrap_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign led_out  = led_out_q;
  assign pwm_wrap = pwm_wrap_q;

endmodule

// File: tb/tb_led_trail_fader.sv
// Bench for led_trail_fader: a fast-decay (DECAY_DIV=4) and a default-decay copy
// share stimulus and are checked against a per-cycle arithmetic model.
module tb_led_trail_fader;

  localparam int MAXL = 15;

  logic       clk = 1'b0;
  logic       nrst, en;
  logic [7:0] led_in;
  logic [7:0] lo_f, lo_s;
  logic       wr_f, wr_s, busy_f, busy_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_trail_fader #(.LVL_W(4), .DECAY_DIV(4)) dut_f (
    .clk(clk), .nrst(nrst), .en(en), .led_in(led_in),
    .led_out(lo_f), .pwm_wrap(wr_f), .busy(busy_f)
  );

  led_trail_fader #(.LVL_W(4), .DECAY_DIV(1024)) dut_s (
    .clk(clk), .nrst(nrst), .en(en), .led_in(led_in),
    .led_out(lo_s), .pwm_wrap(wr_s), .busy(busy_s)
  );

  // Reference model: index 0 = fast copy, index 1 = default copy
  int         m_pwm [2];
  int         m_dec [2];
  int         m_lvl [2][8];
  logic [7:0] m_out [2];
  bit         m_wrap[2];
  int         m_div [2] = '{4, 1024};

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_pwm[d] = 0; m_dec[d] = 0; m_out[d] = 8'h00; m_wrap[d] = 1'b0;
      for (int i = 0; i < 8; i++) m_lvl[d][i] = 0;
    end
  end

  always @(posedge clk) begin
    bit tk;
    for (int d = 0; d < 2; d++) begin
      if (!nrst) begin
        m_pwm[d] = 0; m_dec[d] = 0; m_out[d] = 8'h00; m_wrap[d] = 1'b0;
        for (int i = 0; i < 8; i++) m_lvl[d][i] = 0;
      end else begin
        tk = en && (m_dec[d] == m_div[d] - 1);
        // a channel is lit while the PWM phase is below its level, always at full
        for (int i = 0; i < 8; i++)
          m_out[d][i] = (m_lvl[d][i] == MAXL) || (m_pwm[d] < m_lvl[d][i]);
        m_wrap[d] = en && (m_pwm[d] == MAXL);
        if (en) begin
          m_pwm[d] = (m_pwm[d] + 1) % 16;
          m_dec[d] = (m_dec[d] + 1) % m_div[d];
        end
        for (int i = 0; i < 8; i++) begin
          if (led_in[i]) m_lvl[d][i] = MAXL;
          else if (tk && m_lvl[d][i] > 0) m_lvl[d][i] = m_lvl[d][i] - 1;
        end
      end
    end
  end

  function automatic bit m_busy(int d);
    bit b = 1'b0;
    for (int i = 0; i < 8; i++) if (m_lvl[d][i] != 0) b = 1'b1;
    return b;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0; en = 1'b0; led_in = 8'h00;
    cyc();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b1; led_in = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      cyc();
      total++;
      if (lo_f !== 8'h00 || wr_f !== 1'b0 || busy_f !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got out=%h wrap=%b busy=%b exp 00/0/0", k, lo_f, wr_f, busy_f);
      end
    end
    nrst = 1'b1;
    cyc();
    total++;
    if (busy_f !== 1'b1 || lo_f !== 8'h00) begin
      bad++;
      $display("FAIL reset_release_edge1 got out=%h busy=%b exp 00/1", lo_f, busy_f);
    end
    cyc();
    total++;
    if (lo_f !== 8'hFF || lo_s !== 8'hFF) begin
      bad++;
      $display("FAIL reset_release_edge2 got f=%h s=%h exp ff", lo_f, lo_s);
    end
    total++;
    if (busy_s !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_busy got %b exp 1", busy_s);
    end
    led_in = 8'h00;
  endtask

  task automatic test_decay();
    int fall = -1;
    do_reset();
    en = 1'b1; led_in = 8'h01;
    cyc();
    led_in = 8'h00;
    for (int k = 1; k <= 80; k++) begin
      cyc();
      total++;
      if (lo_f !== m_out[0] || busy_f !== m_busy(0)) begin
        bad++;
        $display("FAIL decay_model k=%0d got out=%h busy=%b exp %h/%b", k, lo_f, busy_f, m_out[0], m_busy(0));
      end
      if (fall < 0 && busy_f === 1'b0) fall = k;
    end
    total++;
    if (fall != 59) begin
      bad++;
      $display("FAIL decay_busy_fall got cycle %0d exp 59", fall);
    end
    total++;
    if (lo_f[0] !== 1'b0) begin
      bad++;
      $display("FAIL decay_led_off got %b exp 0", lo_f[0]);
    end
  endtask

  task automatic test_pwm_duty();
    int hi = 0;
    int wraps = 0;
    do_reset();
    en = 1'b1; led_in = 8'h08;
    cyc();
    led_in = 8'h00;
    repeat (8200) cyc();
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (lo_s[3] === 1'b1) hi++;
      if (wr_s === 1'b1) wraps++;
      total++;
      if (lo_s !== m_out[1]) begin
        bad++;
        $display("FAIL duty_model k=%0d got %h exp %h", k, lo_s, m_out[1]);
      end
    end
    total++;
    if (hi != 7) begin
      bad++;
      $display("FAIL duty_level7 got %0d/16 exp 7/16", hi);
    end
    total++;
    if (wraps != 1) begin
      bad++;
      $display("FAIL duty_wrap_count got %0d exp 1", wraps);
    end
    total++;
    if (busy_s !== 1'b1) begin
      bad++;
      $display("FAIL duty_busy got %b exp 1", busy_s);
    end
  endtask

  task automatic test_hold();
    do_reset();
    en = 1'b1; led_in = 8'h04;
    cyc(); cyc();
    for (int k = 0; k < 24; k++) begin
      cyc();
      total++;
      if (lo_f[2] !== 1'b1 || busy_f !== 1'b1) begin
        bad++;
        $display("FAIL hold_max k=%0d got led2=%b busy=%b exp 1/1", k, lo_f[2], busy_f);
      end
    end
    led_in = 8'h00;
  endtask

  task automatic test_freeze();
    logic [7:0] snap;
    do_reset();
    en = 1'b1; led_in = 8'hA5;
    cyc();
    led_in = 8'h00;
    repeat (10) cyc();
    en = 1'b0;
    cyc();
    snap = m_out[0];
    total++;
    if (lo_f !== snap) begin
      bad++;
      $display("FAIL freeze_entry got %h exp %h", lo_f, snap);
    end
    for (int k = 0; k < 50; k++) begin
      cyc();
      total++;
      if (lo_f !== snap || wr_f !== 1'b0 || busy_f !== 1'b1) begin
        bad++;
        $display("FAIL freeze_hold k=%0d got out=%h wrap=%b busy=%b exp %h/0/1", k, lo_f, wr_f, busy_f, snap);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      total++;
      if (lo_f !== m_out[0] || wr_f !== m_wrap[0] || busy_f !== m_busy(0)) begin
        bad++;
        $display("FAIL freeze_resume k=%0d got %h/%b/%b exp %h/%b/%b", k, lo_f, wr_f, busy_f, m_out[0], m_wrap[0], m_busy(0));
      end
    end
  endtask

  task automatic test_mid_reset();
    int fall = -1;
    do_reset();
    en = 1'b1; led_in = 8'h01;
    cyc();
    led_in = 8'h00;
    for (int k = 0; k < 100 && m_lvl[0][0] != 9; k++) cyc();
    total++;
    if (busy_f !== 1'b1) begin
      bad++;
      $display("FAIL midreset_prefade got busy=%b exp 1", busy_f);
    end
    nrst = 1'b0;
    cyc();
    total++;
    if (lo_f !== 8'h00 || busy_f !== 1'b0 || wr_f !== 1'b0 || lo_s !== 8'h00 || busy_s !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear got f=%h/%b/%b s=%h/%b exp 00/0/0 00/0", lo_f, busy_f, wr_f, lo_s, busy_s);
    end
    nrst = 1'b1; led_in = 8'h01;
    for (int k = 0; k <= 80; k++) begin
      cyc();
      led_in = 8'h00;
      total++;
      if (wr_f !== ((k % 16) == 15)) begin
        bad++;
        $display("FAIL midreset_wrap k=%0d got %b exp %b", k, wr_f, (k % 16) == 15);
      end
      if (fall < 0 && busy_f === 1'b0) fall = k;
    end
    total++;
    if (fall != 59) begin
      bad++;
      $display("FAIL midreset_decay_phase got fall=%0d exp 59", fall);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      nrst = ($urandom_range(0, 199) != 0);
      en   = ($urandom_range(0, 3) != 0);
      led_in = 8'h00;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) == 0) led_in[b] = 1'b1;
      cyc();
      total++;
      if (lo_f !== m_out[0] || wr_f !== m_wrap[0] || busy_f !== m_busy(0)) begin
        bad++;
        $display("FAIL rand_fast k=%0d got %h/%b/%b exp %h/%b/%b", k, lo_f, wr_f, busy_f, m_out[0], m_wrap[0], m_busy(0));
      end
      total++;
      if (lo_s !== m_out[1] || wr_s !== m_wrap[1] || busy_s !== m_busy(1)) begin
        bad++;
        $display("FAIL rand_slow k=%0d got %h/%b/%b exp %h/%b/%b", k, lo_s, wr_s, busy_s, m_out[1], m_wrap[1], m_busy(1));
      end
    end
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; led_in = 8'h00;
    test_reset();
    test_decay();
    test_pwm_duty();
    test_hold();
    test_freeze();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
